// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master round-robin arbiter and sequencer for the shared memory bus
module mem_bus_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rw,
  input  logic [1:0]    m0_size,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rw,
  input  logic [1:0]    m1_size,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,

  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  output logic [1:0]    mem_size,
  input  logic [DW-1:0] mem_rdata,

  output logic [1:0]    gnt,
  output logic          busy
);

  // Counter only needs to reach MEM_LAT-1; keep at least one bit for MEM_LAT=1.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic          last;   // master that won the previous grant
  logic          owner;  // master owning the current transaction
  logic [CW-1:0] cnt;

  logic          any_req;
  logic          pick_m1;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_rw;
  logic [1:0]    sel_size;

  // Round-robin pick: on a tie the master that did not win last time goes next.
  always_comb begin
    any_req   = m0_req | m1_req;
    pick_m1   = (m0_req & m1_req) ? ~last : m1_req;
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
    sel_rw    = pick_m1 ? m1_rw    : m0_rw;
    sel_size  = pick_m1 ? m1_size  : m0_size;
  end

  assign busy = (state != IDLE);

  // Transaction sequencer: grant, hold the bus MEM_LAT cycles, then one response cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      cnt       <= '0;
      gnt       <= 2'b00;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rw    <= 1'b0;
      mem_size  <= 2'b00;
      m0_ack    <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_ack    <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= pick_m1;
            last  <= pick_m1;
            gnt   <= pick_m1 ? 2'b10 : 2'b01;
            if (sel_size == 2'd3) begin
              // Illegal size never touches the bus; answer with err straight away.
              state <= RESP;
              if (pick_m1) m1_err <= 1'b1;
              else         m0_err <= 1'b1;
            end else begin
              state     <= ACCESS;
              cnt       <= CNT_INIT;
              mem_en    <= 1'b1;
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              mem_rw    <= sel_rw;
              mem_size  <= sel_size;
            end
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= 1'b0;
            mem_size  <= 2'b00;
            if (owner) begin
              m1_ack <= 1'b1;
              if (!mem_rw) m1_rdata <= mem_rdata;
            end else begin
              m0_ack <= 1'b1;
              if (!mem_rw) m0_rdata <= mem_rdata;
            end
          end
        end

        RESP: begin
          state  <= IDLE;
          gnt    <= 2'b00;
          m0_ack <= 1'b0;
          m0_err <= 1'b0;
          m1_ack <= 1'b0;
          m1_err <= 1'b0;
        end

        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, rd_val;
  logic [1:0]  m0_size, m1_size;
  logic        m0_ack, m0_err, m1_ack, m1_err, mem_en, mem_rw, busy;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size, gnt;

  logic        u2_req;
  logic        u2_m0_ack, u2_m0_err, u2_m1_ack, u2_m1_err, u2_mem_en, u2_mem_rw, u2_busy;
  logic [31:0] u2_m0_rdata, u2_m1_rdata, u2_mem_addr, u2_mem_wdata;
  logic [1:0]  u2_mem_size, u2_gnt;

  mem_bus_arbiter #(.MEM_LAT(2), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw), .m0_size(m0_size),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw), .m1_size(m1_size),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_size(mem_size), .mem_rdata(rd_val), .gnt(gnt), .busy(busy)
  );

  mem_bus_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) dut2 (
    .clk(clk), .rst(rst),
    .m0_req(u2_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw), .m0_size(m0_size),
    .m0_ack(u2_m0_ack), .m0_err(u2_m0_err), .m0_rdata(u2_m0_rdata),
    .m1_req(1'b0), .m1_addr(32'd0), .m1_wdata(32'd0), .m1_rw(1'b0), .m1_size(2'd0),
    .m1_ack(u2_m1_ack), .m1_err(u2_m1_err), .m1_rdata(u2_m1_rdata),
    .mem_en(u2_mem_en), .mem_addr(u2_mem_addr), .mem_wdata(u2_mem_wdata), .mem_rw(u2_mem_rw),
    .mem_size(u2_mem_size), .mem_rdata(rd_val), .gnt(u2_gnt), .busy(u2_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic        who;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mdl_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every ack/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      if (m0_ack | m0_err | m1_ack | m1_err) begin
        check("resp_single", 32'((m0_ack | m0_err) & (m1_ack | m1_err)), 32'd0);
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_cyc", 32'(cyc), 32'(mon_e.cyc));
          check("resp_who", 32'(m1_ack | m1_err), 32'(mon_e.who));
          check("resp_err", 32'(m0_err | m1_err), 32'(mon_e.err));
          check("resp_ack_err", 32'((m0_ack & m0_err) | (m1_ack & m1_err)), 32'd0);
          check("resp_rdata", mon_e.who ? m1_rdata : m0_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic [31:0] a, input logic [31:0] wd,
                       input logic rw, input logic [1:0] sz);
    if (m == 0) begin
      m0_req = 1'b1; m0_addr = a; m0_wdata = wd; m0_rw = rw; m0_size = sz;
    end else begin
      m1_req = 1'b1; m1_addr = a; m1_wdata = wd; m1_rw = rw; m1_size = sz;
    end
  endtask

  // Expected response for a transaction granted on edge g (MEM_LAT=2 instance).
  task automatic expect_txn(input int m, input int g, input logic rw, input logic [1:0] sz,
                            input logic [31:0] rd);
    exp_t e;
    e.who = (m == 1);
    if (sz == 2'd3) begin
      e.cyc = g; e.err = 1'b1; e.rdata = mdl_rd[m];
    end else begin
      e.cyc = g + 2; e.err = 1'b0;
      if (!rw) mdl_rd[m] = rd;
      e.rdata = mdl_rd[m];
    end
    sb.push_back(e);
  endtask

  initial begin
    int g;
    logic who;
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_rw = 0; m0_size = 0;
    m1_req = 0; m1_addr = 0; m1_wdata = 0; m1_rw = 0; m1_size = 0;
    u2_req = 0; rd_val = 0;
    mdl_rd[0] = 0; mdl_rd[1] = 0;

    // Reset state
    repeat (3) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    rst = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single read by m0; capture must use data of the last ACCESS cycle
    rd_val = 32'hBAD0_BAD0;
    drive(0, 32'h100, 32'h0, 1'b0, 2'd2);
    g = cyc + 1;
    expect_txn(0, g, 1'b0, 2'd2, 32'hDEAD_BEEF);
    tick();
    check("rd_mem_en0", 32'(mem_en), 32'd1);
    check("rd_gnt", 32'(gnt), 32'd1);
    check("rd_addr", mem_addr, 32'h100);
    check("rd_rw", 32'(mem_rw), 32'd0);
    check("rd_busy", 32'(busy), 32'd1);
    rd_val = 32'hDEAD_BEEF;
    tick();
    check("rd_mem_en1", 32'(mem_en), 32'd1);
    tick();
    check("rd_mem_en_off", 32'(mem_en), 32'd0);
    m0_req = 1'b0;
    tick();
    check("rd_gnt_idle", 32'(gnt), 32'd0);
    check("rd_busy_idle", 32'(busy), 32'd0);
    check("rd_hold", m0_rdata, 32'hDEAD_BEEF);
    tick();

    // Write by m1; bus fields stable through ACCESS, rdata untouched
    drive(1, 32'h40, 32'h1234_5678, 1'b1, 2'd2);
    g = cyc + 1;
    expect_txn(1, g, 1'b1, 2'd2, 32'h0);
    tick();
    check("wr_gnt", 32'(gnt), 32'd2);
    check("wr_rw", 32'(mem_rw), 32'd1);
    check("wr_addr", mem_addr, 32'h40);
    check("wr_wdata", mem_wdata, 32'h1234_5678);
    check("wr_size", 32'(mem_size), 32'd2);
    tick();
    check("wr_en1", 32'(mem_en), 32'd1);
    check("wr_wdata1", mem_wdata, 32'h1234_5678);
    check("wr_rw1", 32'(mem_rw), 32'd1);
    tick();
    m1_req = 1'b0;
    tick();
    check("wr_m1_rdata", m1_rdata, 32'd0);
    tick();

    // Contention: both held, strict alternation starting with m0 (m1 won last)
    rd_val = 32'hCAFE_0001;
    drive(0, 32'h200, 32'h0, 1'b0, 2'd1);
    drive(1, 32'h300, 32'h5555_AAAA, 1'b1, 2'd2);
    g = cyc + 1;
    for (int k = 0; k < 4; k++)
      expect_txn(k % 2, g + 4 * k, (k % 2) == 1, (k % 2) == 1 ? 2'd2 : 2'd1, 32'hCAFE_0001);
    for (int k = 0; k < 4; k++) begin
      who = (k % 2) == 1;
      tick();
      check("ct_gnt", 32'(gnt), who ? 32'd2 : 32'd1);
      check("ct_addr", mem_addr, who ? 32'h300 : 32'h200);
      tick();
      tick();
      if (k == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      tick();
      check("ct_gap", 32'(gnt), 32'd0);
    end
    tick();

    // Illegal size: err at once, bus never enabled
    drive(0, 32'h10, 32'h0, 1'b0, 2'd3);
    g = cyc + 1;
    expect_txn(0, g, 1'b0, 2'd3, 32'h0);
    tick();
    check("il_mem_en", 32'(mem_en), 32'd0);
    check("il_busy", 32'(busy), 32'd1);
    check("il_ack", 32'(m0_ack), 32'd0);
    m0_req = 1'b0;
    tick();
    check("il_busy_off", 32'(busy), 32'd0);
    check("il_mem_en_off", 32'(mem_en), 32'd0);
    tick();

    // Reset in the first ACCESS cycle, then m1 alone is granted
    drive(0, 32'h80, 32'h0, 1'b0, 2'd2);
    tick();
    check("rs_mem_en_pre", 32'(mem_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rs_mem_en", 32'(mem_en), 32'd0);
    check("rs_gnt", 32'(gnt), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_addr", mem_addr, 32'd0);
    check("rs_m0_rdata", m0_rdata, 32'd0);
    mdl_rd[0] = 0; mdl_rd[1] = 0;
    m0_req = 1'b0;
    rd_val = 32'h0BAD_F00D;
    drive(1, 32'h44, 32'h0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    g = cyc + 1;
    expect_txn(1, g, 1'b0, 2'd0, 32'h0BAD_F00D);
    tick();
    check("rs_m1_gnt", 32'(gnt), 32'd2);
    check("rs_m1_addr", mem_addr, 32'h44);
    tick();
    tick();
    m1_req = 1'b0;
    tick();
    tick();

    // MEM_LAT=1 instance: single read
    m0_addr = 32'h100; m0_rw = 1'b0; m0_size = 2'd2; m0_wdata = 32'h0;
    rd_val = 32'hDEAD_BEEF;
    u2_req = 1'b1;
    tick();
    check("l1_mem_en", 32'(u2_mem_en), 32'd1);
    check("l1_addr", u2_mem_addr, 32'h100);
    check("l1_gnt", 32'(u2_gnt), 32'd1);
    check("l1_ack_early", 32'(u2_m0_ack), 32'd0);
    tick();
    check("l1_ack", 32'(u2_m0_ack), 32'd1);
    check("l1_mem_en_off", 32'(u2_mem_en), 32'd0);
    check("l1_rdata", u2_m0_rdata, 32'hDEAD_BEEF);
    check("l1_err", 32'(u2_m0_err), 32'd0);
    u2_req = 1'b0;
    tick();
    check("l1_ack_off", 32'(u2_m0_ack), 32'd0);
    check("l1_idle", 32'({u2_busy, u2_gnt, u2_mem_rw, u2_mem_size}), 32'd0);
    check("l1_wdata", u2_mem_wdata, 32'd0);
    check("l1_m1", 32'({u2_m1_ack, u2_m1_err}), 32'd0);
    check("l1_m1_rdata", u2_m1_rdata, 32'd0);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
